// File: rtl/sram_stage_sequencer_pkg.sv
// Shared definitions for the SRAM stage sequencer: defaults, state encoding
// and the stage-selection helper.
package sram_stage_sequencer_pkg;

    localparam int DEF_NUM_STAGES     = 3;
    localparam int DEF_ADDR_W         = 18;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 50_000_000;
    localparam int MAX_STAGES         = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UART_RX,
        S_STG_START,
        S_STG_WAIT
    } seq_state_t;

    typedef logic [$clog2(MAX_STAGES)-1:0] stage_idx_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest non-bypassed stage index in [from, n), or -1 when none remain.
    function automatic int next_stage(input logic [MAX_STAGES-1:0] bypass,
                                      input int from, input int n);
        int sel;
        sel = -1;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (i >= from && i < n && !bypass[i]) begin
                sel = i;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sram_stage_sequencer_idle_timeout_counter.sv
// Counts idle UART cycles; a clear restarts the count from zero.
module idle_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic CLOCK_50_I,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sram_stage_sequencer.sv
// Sequences SRAM ownership: VGA when idle, UART during download, then each
// non-bypassed processing stage in index order.
module sram_stage_sequencer
    import sram_stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                               CLOCK_50_I,
    input  logic                               resetn,
    input  logic                               uart_rx_i,
    output logic                               uart_init_o,
    output logic                               uart_enable_o,
    input  logic [ADDR_W-1:0]                  uart_addr_i,
    input  logic [DATA_W-1:0]                  uart_wdata_i,
    input  logic                               uart_we_n_i,
    input  logic [ADDR_W-1:0]                  vga_addr_i,
    output logic                               vga_enable_o,
    input  logic [NUM_STAGES*ADDR_W-1:0]       stg_addr_i,
    input  logic [NUM_STAGES*DATA_W-1:0]       stg_wdata_i,
    input  logic [NUM_STAGES-1:0]              stg_we_n_i,
    output logic [NUM_STAGES-1:0]              stg_start_o,
    input  logic [NUM_STAGES-1:0]              stg_done_i,
    input  logic [NUM_STAGES-1:0]              stg_bypass_i,
    output logic [ADDR_W-1:0]                  sram_addr_o,
    output logic [DATA_W-1:0]                  sram_wdata_o,
    output logic                               sram_we_n_o,
    output logic [idx_width(NUM_STAGES)-1:0]   active_stage_o,
    output logic                               busy_o
);

    localparam int SIDX_W = idx_width(NUM_STAGES);

    seq_state_t              state_reg;
    stage_idx_t              active_reg;
    logic [NUM_STAGES-1:0]   bypass_reg;
    logic [NUM_STAGES-1:0]   stg_start_reg;
    logic                    uart_init_reg;
    logic                    uart_enable_reg;
    logic                    vga_enable_reg;

    logic [SIDX_W-1:0]       active_idx;
    logic                    timer_clear;
    logic                    timer_enable;
    logic                    timer_expired;
    int                      first_sel;
    int                      next_sel;

    logic [ADDR_W-1:0]       stg_addr_arr  [NUM_STAGES];
    logic [DATA_W-1:0]       stg_wdata_arr [NUM_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_unpack
            assign stg_addr_arr[gi]  = stg_addr_i[gi*ADDR_W +: ADDR_W];
            assign stg_wdata_arr[gi] = stg_wdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign active_idx = SIDX_W'(active_reg);

    // The first pick uses the live mask; the latched copy steers later picks.
    always_comb begin
        first_sel = next_stage(MAX_STAGES'(stg_bypass_i), 0, NUM_STAGES);
        next_sel  = next_stage(MAX_STAGES'(bypass_reg), int'(active_reg) + 1, NUM_STAGES);
    end

    assign timer_clear  = (state_reg != S_UART_RX) || !uart_we_n_i;
    assign timer_enable = (state_reg == S_UART_RX);

    idle_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timeout (
        .CLOCK_50_I(CLOCK_50_I),
        .resetn    (resetn),
        .clear     (timer_clear),
        .enable    (timer_enable),
        .expired   (timer_expired)
    );

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            active_reg      <= '0;
            bypass_reg      <= '0;
            stg_start_reg   <= '0;
            uart_init_reg   <= 1'b0;
            uart_enable_reg <= 1'b0;
            vga_enable_reg  <= 1'b1;
        end else begin
            stg_start_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    uart_init_reg   <= 1'b0;
                    uart_enable_reg <= 1'b0;
                    vga_enable_reg  <= 1'b1;
                    if (!uart_rx_i) begin
                        state_reg      <= S_UART_RX;
                        uart_init_reg  <= 1'b1;
                        vga_enable_reg <= 1'b0;
                    end
                end
                S_UART_RX: begin
                    uart_init_reg <= 1'b0;
                    if (timer_expired) begin
                        uart_enable_reg <= 1'b0;
                        bypass_reg      <= stg_bypass_i;
                        if (first_sel >= 0) begin
                            state_reg                           <= S_STG_START;
                            active_reg                          <= stage_idx_t'(first_sel);
                            stg_start_reg[SIDX_W'(first_sel)]   <= 1'b1;
                        end else begin
                            state_reg      <= S_IDLE;
                            vga_enable_reg <= 1'b1;
                        end
                    end else begin
                        uart_enable_reg <= 1'b1;
                    end
                end
                S_STG_START: begin
                    state_reg <= S_STG_WAIT;
                end
                S_STG_WAIT: begin
                    if (stg_done_i[active_idx]) begin
                        if (next_sel >= 0) begin
                            state_reg                         <= S_STG_START;
                            active_reg                        <= stage_idx_t'(next_sel);
                            stg_start_reg[SIDX_W'(next_sel)]  <= 1'b1;
                        end else begin
                            state_reg      <= S_IDLE;
                            vga_enable_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg       <= S_IDLE;
                    uart_init_reg   <= 1'b0;
                    uart_enable_reg <= 1'b0;
                    vga_enable_reg  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        sram_addr_o  = vga_addr_i;
        sram_wdata_o = '0;
        sram_we_n_o  = 1'b1;
        case (state_reg)
            S_UART_RX: begin
                sram_addr_o  = uart_addr_i;
                sram_wdata_o = uart_wdata_i;
                sram_we_n_o  = uart_we_n_i;
            end
            S_STG_START, S_STG_WAIT: begin
                sram_addr_o  = stg_addr_arr[active_idx];
                sram_wdata_o = stg_wdata_arr[active_idx];
                sram_we_n_o  = stg_we_n_i[active_idx];
            end
            default: begin
                sram_addr_o  = vga_addr_i;
                sram_wdata_o = '0;
                sram_we_n_o  = 1'b1;
            end
        endcase
    end

    assign uart_init_o    = uart_init_reg;
    assign uart_enable_o  = uart_enable_reg;
    assign vga_enable_o   = vga_enable_reg;
    assign stg_start_o    = stg_start_reg;
    assign active_stage_o = active_idx;
    assign busy_o         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer with a phase/queue model checked every cycle.
module tb_sram_stage_sequencer;

    localparam int NS = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TO = 100;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              uart_rx = 1'b1;
    logic              uart_init, uart_enable;
    logic [AW-1:0]     uart_addr = '0;
    logic [DW-1:0]     uart_wdata = '0;
    logic              uart_we_n = 1'b1;
    logic [AW-1:0]     vga_addr = 18'h2BEEF;
    logic              vga_enable;
    logic [AW-1:0]     stg_addr_arr  [NS];
    logic [DW-1:0]     stg_wdata_arr [NS];
    logic [NS*AW-1:0]  stg_addr_flat;
    logic [NS*DW-1:0]  stg_wdata_flat;
    logic [NS-1:0]     stg_we_n = '1;
    logic [NS-1:0]     stg_start;
    logic [NS-1:0]     stg_done = '0;
    logic [NS-1:0]     stg_bypass = '0;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic              sram_we_n;
    logic [1:0]        active_stage;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exit_cyc = 0;
    int starts[$];

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_pack
            assign stg_addr_flat[gi*AW +: AW]  = stg_addr_arr[gi];
            assign stg_wdata_flat[gi*DW +: DW] = stg_wdata_arr[gi];
        end
    endgenerate

    sram_stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLOCK_50_I    (clk),
        .resetn        (resetn),
        .uart_rx_i     (uart_rx),
        .uart_init_o   (uart_init),
        .uart_enable_o (uart_enable),
        .uart_addr_i   (uart_addr),
        .uart_wdata_i  (uart_wdata),
        .uart_we_n_i   (uart_we_n),
        .vga_addr_i    (vga_addr),
        .vga_enable_o  (vga_enable),
        .stg_addr_i    (stg_addr_flat),
        .stg_wdata_i   (stg_wdata_flat),
        .stg_we_n_i    (stg_we_n),
        .stg_start_o   (stg_start),
        .stg_done_i    (stg_done),
        .stg_bypass_i  (stg_bypass),
        .sram_addr_o   (sram_addr),
        .sram_wdata_o  (sram_wdata),
        .sram_we_n_o   (sram_we_n),
        .active_stage_o(active_stage),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: idle / downloading / running a stage, with a to-do list of stages.
    typedef enum int {M_IDLE, M_RX, M_STAGE} mmode_t;
    mmode_t m_mode   = M_IDLE;
    int     m_rx_age = 0;
    int     m_quiet  = 0;
    int     m_age    = 0;
    int     m_cur    = 0;
    int     m_todo[$];

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_mode = M_IDLE; m_cur = 0; m_rx_age = 0; m_quiet = 0; m_age = 0;
            m_todo.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (!uart_rx) begin
                    m_mode = M_RX; m_rx_age = 0; m_quiet = 0;
                end
                M_RX: if (m_quiet == TO - 1) begin
                    m_todo.delete();
                    for (int s = 0; s < NS; s++) if (!stg_bypass[s]) m_todo.push_back(s);
                    if (m_todo.size() == 0) m_mode = M_IDLE;
                    else begin m_cur = m_todo.pop_front(); m_age = 0; m_mode = M_STAGE; end
                end else begin
                    m_rx_age++;
                    m_quiet = uart_we_n ? m_quiet + 1 : 0;
                end
                default: if (m_age > 0 && stg_done[m_cur]) begin
                    if (m_todo.size() == 0) m_mode = M_IDLE;
                    else begin m_cur = m_todo.pop_front(); m_age = 0; end
                end else m_age++;
            endcase
        end
    end

    task automatic cmp_cycle();
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_we;
        logic [NS-1:0] e_start;
        e_start = '0;
        case (m_mode)
            M_IDLE:  begin e_addr = vga_addr;  e_wd = '0;         e_we = 1'b1;      end
            M_RX:    begin e_addr = uart_addr; e_wd = uart_wdata; e_we = uart_we_n; end
            default: begin
                e_addr = stg_addr_arr[m_cur]; e_wd = stg_wdata_arr[m_cur]; e_we = stg_we_n[m_cur];
                if (m_age == 0) e_start[m_cur] = 1'b1;
            end
        endcase
        chk("cyc_busy", busy, m_mode != M_IDLE);
        chk("cyc_vga_enable", vga_enable, m_mode == M_IDLE);
        chk("cyc_uart_init", uart_init, m_mode == M_RX && m_rx_age == 0);
        chk("cyc_uart_enable", uart_enable, m_mode == M_RX && m_rx_age > 0);
        chk("cyc_stg_start", stg_start, e_start);
        chk("cyc_sram_addr", sram_addr, e_addr);
        chk("cyc_sram_wdata", sram_wdata, e_wd);
        chk("cyc_sram_we_n", sram_we_n, e_we);
        if (m_mode == M_STAGE || !resetn) chk("cyc_active_stage", active_stage, m_cur);
    endtask

    logic prev_en = 1'b0;
    initial forever begin
        @(posedge clk);
        #2;
        cmp_cycle();
        for (int j = 0; j < NS; j++) if (stg_start[j]) starts.push_back(j);
        if (prev_en && !uart_enable) exit_cyc = cyc;
        prev_en = uart_enable;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(output int k, input int limit);
        k = -1;
        for (int i = 0; i < limit && k < 0; i++) begin
            for (int j = 0; j < NS; j++) if (stg_start[j]) k = j;
            if (k < 0) @(negedge clk);
        end
        n_checks++;
        if (k < 0) begin
            n_fail++;
            $display("FAIL wait_start: got no start pulse, expected one within %0d cycles", limit);
        end else begin
            $display("stage %0d start pulse at cycle %0d", k, cyc);
        end
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while (busy && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk("wait_idle_busy", busy, 0);
    endtask

    task automatic run_stage(input int k, input int n, input bit inject);
        tick(2);
        if (inject) stg_done[(k + 2) % NS] = 1'b1;
        tick(1);
        stg_done = '0;
        tick(2);
        chk("stage_sram_addr", sram_addr, stg_addr_arr[k]);
        chk("stage_sram_wdata", sram_wdata, stg_wdata_arr[k]);
        chk("stage_active", active_stage, k);
        chk("stage_busy", busy, 1);
        chk("stage_no_restart", stg_start, 0);
        tick(n - 6);
        stg_done[k] = 1'b1;
        tick(1);
        stg_done = '0;
        $display("stage %0d done at cycle %0d", k, cyc);
    endtask

    initial begin
        int k;
        int last_w;
        int entry;
        stg_addr_arr[0]  = 18'h01A00; stg_addr_arr[1]  = 18'h12B11; stg_addr_arr[2]  = 18'h23C22;
        stg_wdata_arr[0] = 16'hA0A0;  stg_wdata_arr[1] = 16'hB1B1;  stg_wdata_arr[2] = 16'hC2C2;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_vga_enable", vga_enable, 1);
        chk("rst_sram_we_n", sram_we_n, 1);
        chk("rst_stg_start", stg_start, 0);
        chk("rst_active", active_stage, 0);
        chk("rst_uart_init", uart_init, 0);
        resetn = 1'b1;
        tick(2);

        // Download: init pulse, writes every 40 cycles, then idle timeout.
        uart_rx = 1'b0;
        tick(1);
        chk("A_init_pulse", uart_init, 1);
        chk("A_vga_off", vga_enable, 0);
        chk("A_enable_not_yet", uart_enable, 0);
        uart_rx = 1'b1;
        tick(1);
        chk("A_init_cleared", uart_init, 0);
        chk("A_enable_on", uart_enable, 1);
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        last_w = 0;
        for (int i = 0; i < 10; i++) begin
            uart_we_n  = 1'b0;
            uart_addr  = AW'(256 + i);
            uart_wdata = DW'(i * 3 + 1);
            last_w     = cyc + 1;
            tick(1);
            uart_we_n = 1'b1;
            $display("uart write %0d sampled at cycle %0d", i, last_w);
            tick(39);
        end
        for (int s = 0; s < NS; s++) begin
            wait_start(k, 200);
            chk("A_start_order", k, s);
            if (k >= 0) run_stage(k, 20, 1'b1);
        end
        chk("A_exit_latency", exit_cyc - last_w, 100);
        chk("A_idle_busy", busy, 0);
        chk("A_idle_vga", vga_enable, 1);
        chk("A_start_count", starts.size(), 3);
        for (int i = 0; i < starts.size() && i < 3; i++) chk("A_start_seq", starts[i], i);

        // Only the middle stage runs when 0 and 2 are bypassed.
        starts.delete();
        stg_bypass = 3'b101;
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        wait_start(k, 150);
        chk("B_only_stage1", k, 1);
        if (k >= 0) run_stage(k, 10, 1'b0);
        chk("B_idle_busy", busy, 0);
        chk("B_start_count", starts.size(), 1);

        // Everything bypassed: straight back to idle, no start pulse.
        starts.delete();
        stg_bypass = 3'b111;
        uart_rx = 1'b0;
        entry = cyc + 1;
        tick(1);
        uart_rx = 1'b1;
        wait_idle(150);
        chk("C_exit_latency", exit_cyc - entry, 100);
        chk("C_no_starts", starts.size(), 0);

        // Reset while stage 1 is writing.
        stg_bypass = 3'b000;
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        wait_start(k, 150);
        chk("D_first_stage", k, 0);
        if (k >= 0) run_stage(k, 8, 1'b0);
        wait_start(k, 20);
        chk("D_second_stage", k, 1);
        tick(2);
        stg_we_n = 3'b101;
        tick(1);
        chk("D_stage_we_n", sram_we_n, 0);
        chk("D_stage_addr", sram_addr, stg_addr_arr[1]);
        resetn = 1'b0;
        #1;
        chk("D_rst_busy", busy, 0);
        chk("D_rst_we_n", sram_we_n, 1);
        chk("D_rst_start", stg_start, 0);
        chk("D_rst_active", active_stage, 0);
        chk("D_rst_vga", vga_enable, 1);
        chk("D_rst_uart_enable", uart_enable, 0);
        chk("D_rst_sram_addr", sram_addr, vga_addr);
        tick(1);
        chk("D_rst_hold_we_n", sram_we_n, 1);
        resetn = 1'b1;
        stg_we_n = '1;
        tick(3);
        chk("D_after_busy", busy, 0);
        chk("D_after_vga", vga_enable, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got no end of stimulus, expected finish before time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
